// File: rtl/cpu_loader_pkg.sv
// Shared definitions for the boot/program loader: command codes, FSM states, header layout.
package cpu_loader_pkg;

  localparam logic [1:0] CMD_LOAD_I = 2'b00;
  localparam logic [1:0] CMD_LOAD_D = 2'b01;
  localparam logic [1:0] CMD_RUN    = 2'b10;
  localparam logic [1:0] CMD_HALT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  localparam int HDR_CMD_MSB  = 31;
  localparam int HDR_CMD_LSB  = 30;
  localparam int HDR_CNT_LSB  = 16;
  localparam int HDR_ADDR_MSB = 15;
  localparam int HDR_ADDR_LSB = 0;

  // Word address to byte address.
  localparam int BYTE_SHIFT = 2;

endpackage

// File: rtl/cpu_loader_mem_port.sv
// Registered write/read port for one cpu memory, with a word-address counter that
// wraps at AW bits. Outputs appear one cycle after the wr/rd strobe.
module cpu_loader_mem_port
  import cpu_loader_pkg::*;
#(
  parameter int AW     = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              start,
  input  logic [15:0]       start_addr,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd,
  output logic [31:0]       addr,
  output logic              wen,
  output logic              ren,
  output logic [DATA_W-1:0] wdata
);

  logic [AW-1:0] word_addr;

  always_ff @(posedge clk) begin
    if (srst) begin
      word_addr <= '0;
      addr      <= '0;
      wen       <= 1'b0;
      ren       <= 1'b0;
      wdata     <= '0;
    end else begin
      wen <= wr;
      ren <= rd;
      if (start) begin
        word_addr <= start_addr[AW-1:0];
      end else if (wr) begin
        word_addr <= word_addr + AW'(1);
      end
      // addr/wdata hold after a write so a following read-back hits the same word.
      if (wr) begin
        addr  <= 32'(word_addr) << BYTE_SHIFT;
        wdata <= wr_data;
      end
    end
  end

endmodule

// File: rtl/cpu_loader.sv
// Boot loader: decodes a header/payload stream into cpu memory writes and drives cpu enable.
// Optional per-word read-back verification is enabled by defining CPU_LOADER_READBACK_EN.
module cpu_loader
  import cpu_loader_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int IMEM_AW = 9,
  parameter int DMEM_AW = 10,
  parameter int CNT_W   = 14
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              cpu_enable,
  output logic [31:0]       imem_addr,
  output logic              imem_wen,
  output logic              imem_ren,
  output logic [DATA_W-1:0] imem_wdata,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [31:0]       dmem_addr,
  output logic              dmem_wen,
  output logic              dmem_ren,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              busy,
  output logic [15:0]       words_loaded
`ifdef CPU_LOADER_READBACK_EN
  ,
  output logic              rb_error
`endif
);

  state_t           state, nxt;
  logic             xfer;
  logic [1:0]       hdr_cmd;
  logic [CNT_W-1:0] hdr_cnt;
  logic             hdr_nonzero;
  logic             tgt_d;
  logic [CNT_W-1:0] remaining;
  logic             start_i, start_d, wr_i, wr_d, rd_i, rd_d;
  logic             run_ok;
`ifdef CPU_LOADER_READBACK_EN
  logic             chk_phase, cmp_pend, rb_sticky, mismatch;
`endif

  assign hdr_cmd     = s_data[HDR_CMD_MSB:HDR_CMD_LSB];
  assign hdr_cnt     = s_data[HDR_CNT_LSB +: CNT_W];
  assign hdr_nonzero = |hdr_cnt;
  assign s_ready     = !srst && (state != ST_CHECK);
  assign xfer        = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (srst) state <= ST_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE, ST_RUN: begin
        if (xfer) begin
          case (hdr_cmd)
            CMD_LOAD_I, CMD_LOAD_D: nxt = hdr_nonzero ? ST_LOAD : ST_IDLE;
            CMD_RUN:                nxt = (state == ST_RUN || run_ok) ? ST_RUN : ST_IDLE;
            default:                nxt = ST_IDLE;
          endcase
        end
      end
      ST_LOAD: begin
        if (xfer) begin
`ifdef CPU_LOADER_READBACK_EN
          nxt = ST_CHECK;
`else
          nxt = (remaining == CNT_W'(1)) ? ST_IDLE : ST_LOAD;
`endif
        end
      end
`ifdef CPU_LOADER_READBACK_EN
      // remaining was already decremented when the word was accepted.
      ST_CHECK: if (chk_phase) nxt = (remaining == '0) ? ST_IDLE : ST_LOAD;
`endif
      default: nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == ST_LOAD) || (state == ST_CHECK);
    start_i = 1'b0;
    start_d = 1'b0;
    wr_i    = 1'b0;
    wr_d    = 1'b0;
    rd_i    = 1'b0;
    rd_d    = 1'b0;
    if (xfer && (state == ST_IDLE || state == ST_RUN) && hdr_nonzero) begin
      start_i = (hdr_cmd == CMD_LOAD_I);
      start_d = (hdr_cmd == CMD_LOAD_D);
    end
    if (xfer && state == ST_LOAD) begin
      wr_i = !tgt_d;
      wr_d = tgt_d;
    end
`ifdef CPU_LOADER_READBACK_EN
    if (state == ST_CHECK && !chk_phase) begin
      rd_i = !tgt_d;
      rd_d = tgt_d;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      tgt_d        <= 1'b0;
      remaining    <= '0;
      cpu_enable   <= 1'b0;
      words_loaded <= '0;
    end else begin
      cpu_enable <= (nxt == ST_RUN);
      if (start_i || start_d) begin
        tgt_d     <= start_d;
        remaining <= hdr_cnt;
      end else if (wr_i || wr_d) begin
        remaining <= remaining - CNT_W'(1);
      end
      if ((wr_i || wr_d) && words_loaded != 16'hFFFF) begin
        words_loaded <= words_loaded + 16'd1;
      end
    end
  end

`ifdef CPU_LOADER_READBACK_EN
  // Compare cycle: rdata from the read issued in the second CHECK cycle against held wdata.
  assign mismatch = cmp_pend && (tgt_d ? (dmem_rdata != dmem_wdata) : (imem_rdata != imem_wdata));
  assign rb_error = rb_sticky || mismatch;
  assign run_ok   = !rb_error;

  always_ff @(posedge clk) begin
    if (srst) begin
      chk_phase <= 1'b0;
      cmp_pend  <= 1'b0;
      rb_sticky <= 1'b0;
    end else begin
      chk_phase <= (state == ST_CHECK) && !chk_phase;
      cmp_pend  <= (state == ST_CHECK) && chk_phase;
      rb_sticky <= rb_sticky || mismatch;
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^{imem_rdata, dmem_rdata};
  assign run_ok       = 1'b1;
`endif

  cpu_loader_mem_port #(.AW(IMEM_AW), .DATA_W(DATA_W)) u_imem (
    .clk        (clk),
    .srst       (srst),
    .start      (start_i),
    .start_addr (s_data[HDR_ADDR_MSB:HDR_ADDR_LSB]),
    .wr         (wr_i),
    .wr_data    (s_data),
    .rd         (rd_i),
    .addr       (imem_addr),
    .wen        (imem_wen),
    .ren        (imem_ren),
    .wdata      (imem_wdata)
  );

  cpu_loader_mem_port #(.AW(DMEM_AW), .DATA_W(DATA_W)) u_dmem (
    .clk        (clk),
    .srst       (srst),
    .start      (start_d),
    .start_addr (s_data[HDR_ADDR_MSB:HDR_ADDR_LSB]),
    .wr         (wr_d),
    .wr_data    (s_data),
    .rd         (rd_d),
    .addr       (dmem_addr),
    .wen        (dmem_wen),
    .ren        (dmem_ren),
    .wdata      (dmem_wdata)
  );

endmodule
